hazard_scoreboard: RTL and testbench

Parametrised, register-indexed hazard scoreboard that replaces the single-load-use stall check at the ID stage. It tracks every in-flight register write with either a fixed countdown (loads, multi-cycle MUL) or a variable-latency busy flag cleared by a completion strobe (divider, cache-miss loads). It stalls the ID stage on RAW and WAW conflicts. Its output drives the PC/IF-ID hold and the ID/EX bubble insertion.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_sb_entry.sv | 54 +++++
 rtl/hazard_scoreboard.sv | 93 +++++++++
 tb/tb_hazard_scoreboard.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the register hazard scoreboard.
// Holds the register-file geometry defaults, the largest fixed latency the
// scoreboard accepts, the derived counter width, and the nominal result
// latencies of each functional unit as seen by the ID stage.
package hazard_pkg;

  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_REG_ADDR_W = $clog2(DEF_NUM_REGS);
  localparam int DEF_MAX_LAT    = 4;
  localparam int DEF_LAT_W      = $clog2(DEF_MAX_LAT + 1);

  // Cycles a consumer must wait after the producer issues (0 = forwardable).
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;

endpackage : hazard_pkg

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: tracks a single architectural register.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   set_fixed  load the countdown with lat (fixed-latency producer issued)
//   set_var    mark the register variable-busy (variable-latency producer issued)
//   lat        fixed latency to load
//   clr_var    completion strobe for this register
//   busy       register has a write still in flight
//   spurious   completion arrived while the entry was not variable-busy
module hazard_sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_fixed,
  input  logic             set_var,
  input  logic [LAT_W-1:0] lat,
  input  logic             clr_var,
  output logic             busy,
  output logic             spurious
);

  logic [LAT_W-1:0] cnt;
  logic             vbusy;

  // NOTE: sequential state uses non-blocking assignments so every entry
  // samples the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (set_fixed) begin
      // A fresh load replaces this cycle's decrement.
      cnt <= lat;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  // An issue and a completion to the same register in one cycle leaves the
  // register busy: the newer producer owns the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbusy <= 1'b0;
    end else if (set_var) begin
      vbusy <= 1'b1;
    end else if (clr_var) begin
      vbusy <= 1'b0;
    end
  end

  assign busy     = (cnt != '0) | vbusy;
  assign spurious = clr_var & ~vbusy;

endmodule : hazard_sb_entry

// File: rtl/hazard_scoreboard.sv
// Register-indexed RAW/WAW hazard scoreboard for the ID stage.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_valid                      instruction present in ID
//   id_rs1/id_rs2, *_used         source indices and read enables
//   id_rd, id_reg_write           destination index and write enable
//   id_lat, id_var_lat            fixed latency / variable-latency producer
//   flush                         squash the ID instruction
//   done_valid, done_rd           variable-latency completion at WB
//   stall                         hold PC and IF/ID, bubble into ID/EX
//   issue                         ID instruction advances this cycle
//   busy_vec                      per-register busy state (bit 0 always 0)
//   err_spurious_done             sticky: completion for a non-variable-busy reg
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MAX_LAT    = DEF_MAX_LAT,
  parameter int LAT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic [LAT_W-1:0]      id_lat,
  input  logic                  id_var_lat,
  input  logic                  flush,
  input  logic                  done_valid,
  input  logic [REG_ADDR_W-1:0] done_rd,
  output logic                  stall,
  output logic                  issue,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  err_spurious_done
);

  if (REG_ADDR_W != $clog2(NUM_REGS)) begin : g_bad_addr_w
    $error("REG_ADDR_W must equal clog2(NUM_REGS)");
  end
  if (LAT_W < $clog2(MAX_LAT + 1)) begin : g_bad_lat_w
    $error("LAT_W too narrow for MAX_LAT");
  end

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] spur_vec;
  logic                raw;
  logic                waw;
  logic                wr_en;
  logic                done_en;

  // Register 0 is hard-wired zero and has no entry.
  assign busy[0]     = 1'b0;
  assign spur_vec[0] = 1'b0;

  assign raw   = (id_rs1_used & busy[id_rs1]) | (id_rs2_used & busy[id_rs2]);
  assign waw   = id_reg_write & (id_rd != '0) & busy[id_rd];
  assign stall = id_valid & ~flush & (raw | waw);
  assign issue = id_valid & ~flush & ~stall;

  assign wr_en   = issue & id_reg_write & (id_rd != '0);
  assign done_en = done_valid & (done_rd != '0);

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hazard_sb_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .set_fixed (wr_en & ~id_var_lat & (id_rd == REG_ADDR_W'(r))),
      .set_var   (wr_en & id_var_lat & (id_rd == REG_ADDR_W'(r))),
      .lat       (id_lat),
      .clr_var   (done_en & (done_rd == REG_ADDR_W'(r))),
      .busy      (busy[r]),
      .spurious  (spur_vec[r])
    );
  end

  assign busy_vec = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_spurious_done <= 1'b0;
    end else if (|spur_vec) begin
      err_spurious_done <= 1'b1;
    end
  end

endmodule : hazard_scoreboard

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. A driver applies stimulus and
// pushes the expected response (from a cycle-timestamp reference model) into
// a queue; a monitor pops and compares on every falling edge.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NR = DEF_NUM_REGS;
  localparam int AW = DEF_REG_ADDR_W;
  localparam int ML = DEF_MAX_LAT;
  localparam int LW = DEF_LAT_W;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd, done_rd;
  logic          id_rs1_used, id_rs2_used, id_reg_write, id_var_lat;
  logic [LW-1:0] id_lat;
  logic          flush, done_valid;
  logic          stall, issue, err_spurious_done;
  logic [NR-1:0] busy_vec;

  hazard_scoreboard dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid          (id_valid),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_rs1_used       (id_rs1_used),
    .id_rs2_used       (id_rs2_used),
    .id_rd             (id_rd),
    .id_reg_write      (id_reg_write),
    .id_lat            (id_lat),
    .id_var_lat        (id_var_lat),
    .flush             (flush),
    .done_valid        (done_valid),
    .done_rd           (done_rd),
    .stall             (stall),
    .issue             (issue),
    .busy_vec          (busy_vec),
    .err_spurious_done (err_spurious_done)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Fixed latencies above MAX_LAT are outside the design's contract.
  always @(negedge clk) begin
    if (!rst && id_valid && id_reg_write && !id_var_lat)
      assert (int'(id_lat) <= ML) else $error("id_lat %0d exceeds MAX_LAT", id_lat);
  end

  typedef struct {
    logic          stall;
    logic          issue;
    logic [NR-1:0] busy;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: a fixed-latency register is busy while the current cycle
  // number is below the cycle at which its result becomes forwardable; a
  // variable-latency register is busy while its completion is pending.
  int cyc = 0;
  int ready_at[NR];
  bit pend[NR];
  bit err_m;

  function automatic bit m_busy(int r);
    return (r != 0) && ((cyc < ready_at[r]) || pend[r]);
  endfunction

  task automatic check(input string name, input logic [NR-1:0] act, input logic [NR-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stall", NR'(stall), NR'(e.stall));
      check("issue", NR'(issue), NR'(e.issue));
      check("busy_vec", busy_vec, e.busy);
      check("err_spurious_done", NR'(err_spurious_done), NR'(e.err));
    end
  end

  task automatic idle_in();
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = '0; id_reg_write = 0; id_lat = '0; id_var_lat = 0; flush = 0;
    done_valid = 0; done_rd = '0;
  endtask

  // Inputs are already applied; predict this cycle, then advance the model.
  task automatic step();
    exp_t e;
    bit   raw, waw, st, is;
    if (rst) begin
      for (int r = 0; r < NR; r++) begin ready_at[r] = 0; pend[r] = 0; end
      err_m = 0;
    end
    raw = (id_rs1_used && m_busy(int'(id_rs1))) || (id_rs2_used && m_busy(int'(id_rs2)));
    waw = id_reg_write && (id_rd != 0) && m_busy(int'(id_rd));
    st  = id_valid && !flush && (raw || waw);
    is  = id_valid && !flush && !st;
    e.stall = st;
    e.issue = is;
    for (int r = 0; r < NR; r++) e.busy[r] = m_busy(r);
    e.err = err_m;
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      if (done_valid && done_rd != 0) begin
        if (pend[done_rd]) pend[done_rd] = 0;
        else err_m = 1;
      end
      if (is && id_reg_write && id_rd != 0) begin
        if (id_var_lat) pend[id_rd] = 1;
        else ready_at[id_rd] = cyc + 1 + int'(id_lat);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic producer(input int rd, input int lat, input bit v);
    idle_in();
    id_valid = 1; id_rd = AW'(rd); id_reg_write = 1; id_lat = LW'(lat); id_var_lat = v;
  endtask

  task automatic consumer(input int rs1, input bit u1, input int rs2, input bit u2);
    idle_in();
    id_valid = 1; id_rs1 = AW'(rs1); id_rs1_used = u1; id_rs2 = AW'(rs2); id_rs2_used = u2;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int pl[$];
    idle_in();
    rst = 1;
    id_valid = 1;
    step(); step();
    rst = 0;
    idle_in(); step();

    // Load-use: one bubble.
    producer(5, LAT_LOAD, 0); step();
    consumer(5, 1, 0, 0); step(); step();
    idle_in(); step();

    // MUL: three stall cycles, busy 1,1,1,0.
    producer(7, LAT_MUL, 0); step();
    consumer(0, 0, 7, 1); repeat (4) step();

    // Divide: held until completion, then a spurious second completion.
    producer(9, 0, 1); step();
    consumer(9, 1, 0, 0); repeat (20) step();
    done_valid = 1; done_rd = 9; step();
    done_valid = 0; step();
    idle_in(); done_valid = 1; done_rd = 9; step();
    idle_in(); repeat (3) step();

    // WAW behind a variable-latency producer, then x0 behaviour.
    producer(4, 0, 1); step();
    producer(4, LAT_ALU, 0); repeat (3) step();
    done_valid = 1; done_rd = 4; step();
    done_valid = 0; step();
    producer(0, 3, 0); step();
    consumer(0, 1, 0, 1); step();
    idle_in(); done_valid = 1; done_rd = 0; step();

    // Flush: no update for the squashed instruction; older producer keeps counting.
    producer(6, 2, 0); flush = 1; step();
    producer(2, 3, 0); step();
    consumer(2, 1, 0, 0); flush = 1; step(); step();
    flush = 0; repeat (2) step();

    // Reset mid-flight with cnt[3]=2 and vbusy[8]=1.
    producer(3, 3, 0); step();
    producer(8, 0, 1); step();
    consumer(3, 1, 8, 1); rst = 1; step();
    rst = 0; step();

    // Same-cycle variable issue and completion to one register: issue wins.
    producer(10, 0, 1); done_valid = 1; done_rd = 10; step();
    consumer(10, 1, 0, 0); repeat (2) step();
    done_valid = 1; done_rd = 10; step();
    done_valid = 0; step();

    // Randomised traffic on a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      idle_in();
      id_valid     = ($urandom_range(0, 9) < 8);
      id_rs1       = AW'($urandom_range(0, 7));
      id_rs2       = AW'($urandom_range(0, 7));
      id_rs1_used  = 1'($urandom);
      id_rs2_used  = 1'($urandom);
      id_rd        = AW'($urandom_range(0, 7));
      id_reg_write = 1'($urandom);
      id_var_lat   = ($urandom_range(0, 4) == 0);
      id_lat       = LW'($urandom_range(0, ML));
      flush        = ($urandom_range(0, 9) == 0);
      rst          = ($urandom_range(0, 199) == 0);
      pl.delete();
      for (int r = 1; r < 8; r++) if (pend[r]) pl.push_back(r);
      if ($urandom_range(0, 5) == 0) begin
        done_valid = 1;
        if (pl.size() > 0 && $urandom_range(0, 7) != 0)
          done_rd = AW'(pl[$urandom_range(0, pl.size() - 1)]);
        else
          done_rd = AW'($urandom_range(0, 7));
      end
      step();
    end
    rst = 0;
    idle_in(); step();

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("queue_drained", NR'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_hazard_scoreboard
